fix_ingress_framer: RTL and testbench

Store-and-forward byte framer that sits directly upstream of the FIX parser top and drives its `data_i` stream. It accepts raw bytes from the line interface and finds FIX frame boundaries: a frame starts with `8` and ends with `<SOH>10=ddd<SOH>`. It verifies the FIX checksum and releases only verified frames, byte by byte, to the parser. Bad, junk and oversized data never reaches the parser.

---
 rtl/fix_ingress_framer.sv | 237 +++++++++++++++++++++++
 tb/tb_fix_ingress_framer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fix_ingress_framer.sv
// Store-and-forward FIX framer: buffers bytes from the line, verifies the
// trailing 10=ddd checksum and releases only committed frames to the parser.
module fix_ingress_framer #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  input  logic        out_ready_i,
  output logic        frame_good_o,
  output logic        frame_bad_o,
  output logic        overflow_o,
  output logic        junk_o,
  output logic [15:0] good_count_o,
  output logic [15:0] bad_count_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_P = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_P   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_BODY, S_SAW_SOH, S_T1, S_T10, S_CK0, S_CK1, S_CK2, S_CK_END
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_q, wr_d, commit_q, commit_d, rd_q, rd_d, start_q, start_d;
  logic [7:0]  sum_q, sum_d, sum_soh_q, sum_soh_d;
  logic [9:0]  ck_q, ck_d;
  logic        bad_q, bad_d, drop_q, drop_d;
  logic        good_p_q, good_p_d, bad_p_q, bad_p_d, ovf_p_q, ovf_p_d, junk_p_q, junk_p_d;
  logic [15:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [7:0]  mem_q [0:DEPTH-1];

  logic [AW:0] used_s;
  logic        full_s, acc_s, ovf_s, wr_en_s, is_soh_s, is_digit_s, load_s;
  logic [7:0]  sum_next_s, digit_s;
  logic [9:0]  ck_step_s;

  assign used_s     = wr_q - rd_q;
  assign full_s     = (used_s == DEPTH_P);
  assign in_ready_o = !full_s || drop_q;
  assign acc_s      = in_valid_i && in_ready_o;
  // A frame that fills the RAM while nothing committed remains can never complete.
  assign ovf_s      = (state_q != S_IDLE) && full_s && in_valid_i &&
                      (commit_q == rd_q) && !drop_q;
  assign wr_en_s    = acc_s && !drop_q &&
                      ((state_q != S_IDLE) || (in_data_i == 8'h38));
  assign is_soh_s   = (in_data_i == 8'h01);
  assign is_digit_s = (in_data_i >= 8'h30) && (in_data_i <= 8'h39);
  assign sum_next_s = sum_q + in_data_i;
  assign digit_s    = in_data_i - 8'h30;
  assign ck_step_s  = (ck_q * 10'd10) + {2'b00, digit_s};

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    commit_d  = commit_q;
    start_d   = start_q;
    sum_d     = sum_q;
    sum_soh_d = sum_soh_q;
    ck_d      = ck_q;
    bad_d     = bad_q;
    drop_d    = drop_q;
    good_p_d  = 1'b0;
    bad_p_d   = 1'b0;
    ovf_p_d   = 1'b0;
    junk_p_d  = 1'b0;
    if (ovf_s) begin
      wr_d    = start_q;
      drop_d  = 1'b1;
      ovf_p_d = 1'b1;
    end else if (acc_s) begin
      if (wr_en_s) begin
        wr_d = wr_q + ONE_P;
      end else begin
        wr_d = wr_q;
      end
      sum_d = sum_next_s;
      case (state_q)
        S_IDLE: begin
          if (in_data_i == 8'h38) begin
            start_d = wr_q;
            sum_d   = 8'h38;
            state_d = S_BODY;
          end else begin
            sum_d    = sum_q;
            junk_p_d = 1'b1;
          end
        end
        S_BODY, S_SAW_SOH, S_T1, S_T10: begin
          if (is_soh_s) begin
            sum_soh_d = sum_next_s;
            state_d   = S_SAW_SOH;
          end else if ((state_q == S_SAW_SOH) && (in_data_i == 8'h31)) begin
            state_d = S_T1;
          end else if ((state_q == S_T1) && (in_data_i == 8'h30)) begin
            state_d = S_T10;
          end else if ((state_q == S_T10) && (in_data_i == 8'h3D)) begin
            ck_d    = 10'd0;
            state_d = S_CK0;
          end else begin
            state_d = S_BODY;
          end
        end
        S_CK0, S_CK1, S_CK2: begin
          if (is_digit_s) begin
            ck_d = ck_step_s;
          end else begin
            bad_d = 1'b1;
          end
          if (state_q == S_CK0) begin
            state_d = S_CK1;
          end else if (state_q == S_CK1) begin
            state_d = S_CK2;
          end else begin
            state_d = S_CK_END;
          end
        end
        S_CK_END: begin
          state_d = S_IDLE;
          bad_d   = 1'b0;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (is_soh_s && !bad_q && (ck_q == {2'b00, sum_soh_q})) begin
            commit_d = wr_q + ONE_P;
            good_p_d = 1'b1;
          end else begin
            wr_d    = start_q;
            bad_p_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output stage reloads from committed RAM whenever it is empty or draining.
  always_comb begin
    load_s      = (!out_valid_q || out_ready_i) && (rd_q != commit_q);
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load_s) begin
      rd_d        = rd_q + ONE_P;
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_q[AW-1:0]];
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
      out_data_d  = 8'h00;
    end else begin
      out_valid_d = out_valid_q;
    end
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (good_p_d && (good_cnt_q != 16'hFFFF)) begin
      good_cnt_d = good_cnt_q + 16'd1;
    end else begin
      good_cnt_d = good_cnt_q;
    end
    if ((bad_p_d || ovf_p_d) && (bad_cnt_q != 16'hFFFF)) begin
      bad_cnt_d = bad_cnt_q + 16'd1;
    end else begin
      bad_cnt_d = bad_cnt_q;
    end
  end

  // Frame RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_q[AW-1:0]] <= in_data_i;
    end
  end

  // State, pointers, status pulses and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_q        <= '0;
      commit_q    <= '0;
      rd_q        <= '0;
      start_q     <= '0;
      sum_q       <= 8'h00;
      sum_soh_q   <= 8'h00;
      ck_q        <= 10'd0;
      bad_q       <= 1'b0;
      drop_q      <= 1'b0;
      good_p_q    <= 1'b0;
      bad_p_q     <= 1'b0;
      ovf_p_q     <= 1'b0;
      junk_p_q    <= 1'b0;
      good_cnt_q  <= 16'd0;
      bad_cnt_q   <= 16'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      commit_q    <= commit_d;
      rd_q        <= rd_d;
      start_q     <= start_d;
      sum_q       <= sum_d;
      sum_soh_q   <= sum_soh_d;
      ck_q        <= ck_d;
      bad_q       <= bad_d;
      drop_q      <= drop_d;
      good_p_q    <= good_p_d;
      bad_p_q     <= bad_p_d;
      ovf_p_q     <= ovf_p_d;
      junk_p_q    <= junk_p_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign frame_good_o = good_p_q;
  assign frame_bad_o  = bad_p_q;
  assign overflow_o   = ovf_p_q;
  assign junk_o       = junk_p_q;
  assign good_count_o = good_cnt_q;
  assign bad_count_o  = bad_cnt_q;

endmodule

// File: tb/tb_fix_ingress_framer.sv
// Directed bench for fix_ingress_framer with a 16-byte FIFO (AW=4).
module tb_fix_ingress_framer;
  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready_o, out_valid_o, frame_good_o, frame_bad_o, overflow_o, junk_o;
  logic [7:0]  out_data_o;
  logic [15:0] good_count_o, bad_count_o;

  always #5 clk = ~clk;

  fix_ingress_framer #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready),
    .frame_good_o(frame_good_o), .frame_bad_o(frame_bad_o),
    .overflow_o(overflow_o), .junk_o(junk_o),
    .good_count_o(good_count_o), .bad_count_o(bad_count_o)
  );

  int errors = 0;
  int checks = 0;
  int n_good = 0, n_bad = 0, n_ovf = 0, n_junk = 0;
  int multi_err = 0, hold_err = 0, zero_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] out_q [$];

  // Checksums: 56+61+65+1=183, 56+61+66+1=184, 56+61+10*65+1=768 -> 000.
  string GOOD   = "8=A\00110=183\001";
  string BAD    = "8=A\00110=184\001";
  string GOOD_B = "8=B\00110=184\001";
  string OVF    = "8=AAAAAAAAAA\00110=000\001";
  string MID    = "8=ABC";

  // Sampled on the falling edge, between input drive points.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid_o && out_ready) out_q.push_back(out_data_o);
      if (frame_good_o) n_good <= n_good + 1;
      if (frame_bad_o)  n_bad  <= n_bad + 1;
      if (overflow_o)   n_ovf  <= n_ovf + 1;
      if (junk_o)       n_junk <= n_junk + 1;
      if ((int'(frame_good_o) + int'(frame_bad_o) + int'(overflow_o)) > 1) multi_err <= multi_err + 1;
      if (!out_valid_o && (out_data_o != 8'h00)) zero_err <= zero_err + 1;
      if (prev_stall && (!out_valid_o || (out_data_o != prev_data))) hold_err <= hold_err + 1;
      prev_stall <= out_valid_o && !out_ready;
      prev_data  <= out_data_o;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready_o && t < 100) begin
      tick(1);
      t++;
    end
    if (t >= 100) check_val("in_ready_timeout", 32'd0, 32'd1);
    tick(1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic expect_out(input string tag, input string s);
    int t = 0;
    while ((out_q.size() < s.len()) && (t < 300)) begin
      tick(1);
      t++;
    end
    tick(4);
    check_val({tag, "_len"}, out_q.size(), s.len());
    for (int i = 0; (i < s.len()) && (i < out_q.size()); i++)
      check_val({tag, "_byte"}, {24'h0, out_q[i]}, {24'h0, s[i]});
    out_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    tick(3);
    check_val("rst_in_ready", in_ready_o, 1);
    check_val("rst_out_valid", out_valid_o, 0);
    check_val("rst_out_data", out_data_o, 0);
    check_val("rst_pulses", {frame_good_o, frame_bad_o, overflow_o, junk_o}, 0);
    check_val("rst_counts", {good_count_o, bad_count_o}, 0);
    rst = 1'b1;
    tick(2);

    send_str(GOOD);
    expect_out("good", GOOD);
    check_val("good_pulses", n_good, 1);
    check_val("good_count", good_count_o, 1);

    send_str(BAD);
    tick(10);
    check_val("bad_no_out", out_q.size(), 0);
    check_val("bad_pulses", n_bad, 1);
    check_val("bad_count", bad_count_o, 1);
    send_str(GOOD);
    expect_out("after_bad", GOOD);

    send_str("XY");
    send_str(GOOD);
    expect_out("junk", GOOD);
    check_val("junk_pulses", n_junk, 2);
    check_val("junk_good_count", good_count_o, 3);

    send_str(OVF);
    tick(10);
    check_val("ovf_no_out", out_q.size(), 0);
    check_val("ovf_pulses", n_ovf, 1);
    check_val("ovf_bad_count", bad_count_o, 2);
    check_val("ovf_in_ready", in_ready_o, 1);
    send_str(GOOD);
    expect_out("after_ovf", GOOD);
    check_val("after_ovf_count", good_count_o, 4);

    out_ready = 1'b0;
    fork
      begin
        send_str(GOOD);
        send_str(GOOD_B);
      end
      begin
        tick(30);
        check_val("bp_full", in_ready_o, 0);
        check_val("bp_held_valid", out_valid_o, 1);
        out_ready = 1'b1;
      end
    join
    expect_out("bp", {GOOD, GOOD_B});
    check_val("bp_good_count", good_count_o, 6);

    for (int i = 0; i < MID.len(); i++) send_byte(MID[i]);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_val("mid_in_ready", in_ready_o, 1);
    check_val("mid_out_valid", out_valid_o, 0);
    check_val("mid_pulses", {frame_good_o, frame_bad_o, overflow_o, junk_o}, 0);
    check_val("mid_counts", {good_count_o, bad_count_o}, 0);
    tick(2);
    rst = 1'b1;
    tick(3);
    check_val("mid_no_pulse", n_bad + n_ovf, 2);
    send_str(GOOD);
    expect_out("after_mid", GOOD);
    check_val("after_mid_count", good_count_o, 1);
    check_val("after_mid_pulses", n_good, 7);

    check_val("one_pulse_per_cycle", multi_err, 0);
    check_val("stall_hold", hold_err, 0);
    check_val("idle_data_zero", zero_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
